// File: rtl/gh_counter_ud_reload_tc_if.sv
// Bundle of control inputs and count/status outputs for the reloadable
// up/down counter. The master drives controls; the slave is the counter.
//
// Signalling: there is no valid/ready pair here. Every control (ce, start,
// stop, load, rld_we) is a single-cycle qualifier sampled on the rising clock
// edge. It takes effect on that edge with no back-pressure. The only
// zero-latency output is tc, which is valid whenever ce is.
interface gh_counter_ud_reload_tc_if #(
  parameter int SIZE = 8
);
  logic            ce;
  logic            dir;
  logic            oneshot;
  logic            start;
  logic            stop;
  logic            load;
  logic [SIZE-1:0] d;
  logic            rld_we;
  logic [SIZE-1:0] rld_d;
  logic [SIZE-1:0] q;
  logic [SIZE-1:0] rld;
  logic            run;
  logic            done;
  logic            tc;

  modport master (
    output ce, dir, oneshot, start, stop, load, d, rld_we, rld_d,
    input  q, rld, run, done, tc
  );

  modport slave (
    input  ce, dir, oneshot, start, stop, load, d, rld_we, rld_d,
    output q, rld, run, done, tc
  );
endinterface

// File: rtl/gh_counter_ud_reload_tc.sv
// General-purpose up/down timer with reload register, periodic or one-shot
// operation, and a combinational terminal-count strobe.
module gh_counter_ud_reload_tc #(
  parameter int              SIZE     = 8,
  parameter logic [SIZE-1:0] RLD_INIT = '0
) (
  input logic                     clk,
  input logic                     rst,
  gh_counter_ud_reload_tc_if.slave bus
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] reload_q, reload_d;
  logic            run_q, run_d;
  logic            done_q, done_d;
  logic            at_term;
  logic [SIZE-1:0] sv_start;
  logic [SIZE-1:0] sv_reload;

  // Terminal compare and start values follow the live dir input; only a
  // start may bypass a same-cycle reload write.
  always_comb begin
    at_term   = bus.dir ? (q_q == reload_q) : (q_q == '0);
    sv_reload = bus.dir ? '0 : reload_q;
    sv_start  = bus.dir ? '0 : (bus.rld_we ? bus.rld_d : reload_q);
  end

  // Next-state: load > start > stop > terminal > step > hold.
  always_comb begin
    q_d      = q_q;
    run_d    = run_q;
    done_d   = done_q;
    reload_d = bus.rld_we ? bus.rld_d : reload_q;
    if (bus.load) begin
      q_d    = bus.d;
      done_d = 1'b0;
    end else if (bus.start) begin
      q_d    = sv_start;
      run_d  = 1'b1;
      done_d = 1'b0;
    end else if (bus.stop) begin
      run_d = 1'b0;
    end else if (run_q && bus.ce && at_term) begin
      if (bus.oneshot) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        q_d = sv_reload;
      end
    end else if (run_q && bus.ce) begin
      q_d = bus.dir ? (q_q + ONE) : (q_q - ONE);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= '0;
      reload_q <= RLD_INIT;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  // Outputs; tc is the enabled cycle that consumes the terminal value.
  always_comb begin
    bus.q    = q_q;
    bus.rld  = reload_q;
    bus.run  = run_q;
    bus.done = done_q;
    bus.tc   = run_q & bus.ce & at_term;
  end

endmodule
